hazard_stall_ctrl: RTL and testbench

//   Producer-side companion of the ID/EX operand-forwarding logic: detects hazards forwarding cannot cover
//   and drives stall, bubble and flush controls for the 5-stage MIPS pipeline. Covers load-use hazards,
//   ID-stage branch operand hazards, I$/D$ miss freezes and taken branch/jump flushes. Holds a flush

---
 rtl/hazard_stall_ctrl_if.sv | 42 ++++
 rtl/hazard_stall_ctrl.sv | 115 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline hazard/stall control bundle: hazard sources from ID/EX/MEM and the caches,
// stall/bubble/flush controls back to the pipeline registers.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       iRs_RegD;
  logic [4:0]       iRt_RegD;
  logic             iUseRt_D;
  logic             iBranch_D;
  logic             iTaken_D;
  logic             iMemRead_RegE;
  logic             iRegWrite_RegE;
  logic [4:0]       iwsel_RegE;
  logic             iMemRead_RegM;
  logic [4:0]       iwsel_RegM;
  logic             iICacheStall;
  logic             iDCacheStall;
  logic             oPC_En;
  logic             oIFID_En;
  logic             oIFID_Flush;
  logic             oIDEX_Bubble;
  logic             oPipe_En;
  logic [CNT_W-1:0] oStallCnt;
  logic [CNT_W-1:0] oFlushCnt;
  logic [1:0]       st;

  modport master (
    output iRs_RegD, iRt_RegD, iUseRt_D, iBranch_D, iTaken_D,
           iMemRead_RegE, iRegWrite_RegE, iwsel_RegE,
           iMemRead_RegM, iwsel_RegM, iICacheStall, iDCacheStall,
    input  oPC_En, oIFID_En, oIFID_Flush, oIDEX_Bubble, oPipe_En,
           oStallCnt, oFlushCnt, st
  );

  modport slave (
    input  iRs_RegD, iRt_RegD, iUseRt_D, iBranch_D, iTaken_D,
           iMemRead_RegE, iRegWrite_RegE, iwsel_RegE,
           iMemRead_RegM, iwsel_RegM, iICacheStall, iDCacheStall,
    output oPC_En, oIFID_En, oIFID_Flush, oIDEX_Bubble, oPipe_En,
           oStallCnt, oFlushCnt, st
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard detection for the 5-stage MIPS pipeline: load-use and ID-branch stalls, cache freezes,
// taken-branch flushes (deferred across a freeze) and saturating stall/flush counters.
module hazard_stall_ctrl #(
  parameter int CNT_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  hazard_stall_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FREEZE = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  state_t           st;
  logic             pendFlush;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  logic freeze;
  logic rsHitE, rtHitE, rsHitM, rtHitM;
  logic ldUse, brHaz, hazard, stall, flushReq;
  logic pcEn, ifidEn, ifidFlush, idexBubble, pipeEn;

  function automatic logic match(input logic [4:0] r, input logic [4:0] w);
    return (w != 5'd0) && (w == r);
  endfunction

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    freeze = bus.iICacheStall | bus.iDCacheStall;
    rsHitE = match(bus.iRs_RegD, bus.iwsel_RegE);
    rtHitE = bus.iUseRt_D && match(bus.iRt_RegD, bus.iwsel_RegE);
    rsHitM = match(bus.iRs_RegD, bus.iwsel_RegM);
    rtHitM = bus.iUseRt_D && match(bus.iRt_RegD, bus.iwsel_RegM);

    ldUse  = bus.iMemRead_RegE && (rsHitE || rtHitE);
    brHaz  = bus.iBranch_D &&
             ((bus.iRegWrite_RegE && (rsHitE || rtHitE)) ||
              (bus.iMemRead_RegM && (rsHitM || rtHitM)));
    hazard = ldUse || brHaz;
    stall  = !freeze && hazard;

    // A redirect seen during a freeze is replayed on the first unfrozen cycle via pendFlush
    flushReq = (bus.iTaken_D && !stall && !freeze) || (pendFlush && !freeze);
  end

  always_comb begin
    pcEn       = 1'b1;
    ifidEn     = 1'b1;
    ifidFlush  = 1'b0;
    idexBubble = 1'b0;
    pipeEn     = 1'b1;
    if (!rst) begin
      if (freeze) begin
        pcEn   = 1'b0;
        ifidEn = 1'b0;
        pipeEn = 1'b0;
      end else begin
        if (stall) begin
          pcEn       = 1'b0;
          ifidEn     = 1'b0;
          idexBubble = 1'b1;
        end
        ifidFlush = flushReq;
      end
    end
  end

  assign bus.oPC_En       = pcEn;
  assign bus.oIFID_En     = ifidEn;
  assign bus.oIFID_Flush  = ifidFlush;
  assign bus.oIDEX_Bubble = idexBubble;
  assign bus.oPipe_En     = pipeEn;
  assign bus.oStallCnt    = stallCnt;
  assign bus.oFlushCnt    = flushCnt;
  assign bus.st           = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= RUN;
      pendFlush <= 1'b0;
      stallCnt  <= '0;
      flushCnt  <= '0;
    end else begin
      case (st)
        RUN: begin
          if (freeze)     st <= FREEZE;
          else if (stall) st <= BUBBLE;
        end
        BUBBLE: begin
          if (freeze)      st <= FREEZE;
          else if (!stall) st <= RUN;
        end
        FREEZE: begin
          if (!freeze) st <= stall ? BUBBLE : RUN;
        end
        default: st <= RUN;
      endcase

      // Cleared on the cycle it is applied so one redirect never flushes twice
      if (freeze && bus.iTaken_D && !hazard) pendFlush <= 1'b1;
      else if (!freeze)                      pendFlush <= 1'b0;

      if (!pcEn)     stallCnt <= satInc(stallCnt);
      if (ifidFlush) flushCnt <= satInc(flushCnt);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl with a queue-based scoreboard and a negedge monitor.
module tb_hazard_stall_ctrl;
  localparam int CNT_W = 4;
  localparam logic [4:0] NORM  = 5'b11001; // {pc, ifid, flush, bubble, pipe}
  localparam logic [4:0] STALL = 5'b00011;
  localparam logic [4:0] FRZ   = 5'b00000;
  localparam logic [4:0] FLUSH = 5'b11101;
  localparam int RUN = 0, FREEZE = 1, BUBBLE = 2;

  typedef struct {
    int       id;
    logic [4:0] ctl;
    int       sc;
    int       fc;
    int       st;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nChecks = 0;
  int   nFail = 0;
  int   vecId = 0;
  exp_t sbq[$];

  hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();
  hazard_stall_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input int id, input int act, input int req);
    nChecks++;
    if (act != req) begin
      nFail++;
      $display("FAIL %s vec%0d: got %0d expected %0d", name, id, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      check("oPC_En",       e.id, int'(bus.oPC_En),       int'(e.ctl[4]));
      check("oIFID_En",     e.id, int'(bus.oIFID_En),     int'(e.ctl[3]));
      check("oIFID_Flush",  e.id, int'(bus.oIFID_Flush),  int'(e.ctl[2]));
      check("oIDEX_Bubble", e.id, int'(bus.oIDEX_Bubble), int'(e.ctl[1]));
      check("oPipe_En",     e.id, int'(bus.oPipe_En),     int'(e.ctl[0]));
      check("oStallCnt",    e.id, int'(bus.oStallCnt),    e.sc);
      check("oFlushCnt",    e.id, int'(bus.oFlushCnt),    e.fc);
      check("st",           e.id, int'(bus.st),           e.st);
    end
  end

  task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic useRt,
                       input logic br, input logic tk, input logic mE, input logic wE,
                       input logic [4:0] wsE, input logic mM, input logic [4:0] wsM,
                       input logic ic, input logic dc,
                       input logic [4:0] ctl, input int sc, input int fc, input int st);
    exp_t e;
    @(posedge clk);
    #1;
    rst                = r;
    bus.iRs_RegD       = rs;
    bus.iRt_RegD       = rt;
    bus.iUseRt_D       = useRt;
    bus.iBranch_D      = br;
    bus.iTaken_D       = tk;
    bus.iMemRead_RegE  = mE;
    bus.iRegWrite_RegE = wE;
    bus.iwsel_RegE     = wsE;
    bus.iMemRead_RegM  = mM;
    bus.iwsel_RegM     = wsM;
    bus.iICacheStall   = ic;
    bus.iDCacheStall   = dc;
    e.id = vecId; e.ctl = ctl; e.sc = sc; e.fc = fc; e.st = st;
    sbq.push_back(e);
    vecId++;
  endtask

  task automatic idle(input logic [4:0] ctl, input int sc, input int fc, input int st);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ctl, sc, fc, st);
  endtask

  initial begin
    bus.iRs_RegD = 0; bus.iRt_RegD = 0; bus.iUseRt_D = 0; bus.iBranch_D = 0;
    bus.iTaken_D = 0; bus.iMemRead_RegE = 0; bus.iRegWrite_RegE = 0; bus.iwsel_RegE = 0;
    bus.iMemRead_RegM = 0; bus.iwsel_RegM = 0; bus.iICacheStall = 0; bus.iDCacheStall = 0;
    repeat (2) @(posedge clk);

    // reset forces normal controls even with a load-use present
    drive(1, 8, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0, 0, NORM, 0, 0, RUN);
    idle(NORM, 0, 0, RUN);
    // load-use on rs
    drive(0, 8, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0, 0, STALL, 0, 0, RUN);
    idle(NORM, 1, 0, BUBBLE);
    idle(NORM, 1, 0, RUN);
    // $zero destination and unused rt never stall; used rt does
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, NORM, 1, 0, RUN);
    drive(0, 3, 8, 0, 0, 0, 1, 0, 8, 0, 0, 0, 0, NORM, 1, 0, RUN);
    drive(0, 3, 8, 1, 0, 0, 1, 0, 8, 0, 0, 0, 0, STALL, 1, 0, RUN);
    idle(NORM, 2, 0, BUBBLE);
    // branch operand hazard against EX, then against a load in MEM
    drive(0, 0, 5, 1, 1, 0, 0, 1, 5, 0, 0, 0, 0, STALL, 2, 0, RUN);
    drive(0, 0, 5, 1, 1, 0, 0, 0, 0, 1, 5, 0, 0, STALL, 3, 0, BUBBLE);
    idle(NORM, 4, 0, BUBBLE);
    idle(NORM, 4, 0, RUN);
    // taken branch during I$ freeze is deferred to the first unfrozen cycle
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, FRZ, 4, 0, RUN);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, FRZ, 5, 0, FREEZE);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, FRZ, 6, 0, FREEZE);
    idle(FLUSH, 7, 0, FREEZE);
    idle(NORM, 7, 1, RUN);
    // direct taken branch
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, FLUSH, 7, 1, RUN);
    idle(NORM, 7, 2, RUN);
    // D$ freeze beats load-use; bubble follows release
    drive(0, 8, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0, 1, FRZ, 7, 2, RUN);
    drive(0, 8, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0, 0, STALL, 8, 2, FREEZE);
    idle(NORM, 9, 2, BUBBLE);
    // stall suppresses a taken-branch flush
    drive(0, 8, 0, 0, 0, 1, 1, 0, 8, 0, 0, 0, 0, STALL, 9, 2, RUN);
    idle(NORM, 10, 2, BUBBLE);
    // reset mid-freeze discards the pending flush
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, FRZ, 10, 2, RUN);
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, NORM, 11, 2, FREEZE);
    idle(NORM, 0, 0, RUN);
    // 20 back-to-back stalls saturate the 4-bit counter
    for (int i = 0; i < 20; i++)
      drive(0, 8, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0, 0, STALL, (i < 15) ? i : 15, 0,
            (i == 0) ? RUN : BUBBLE);
    drive(1, 8, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0, 0, NORM, 15, 0, BUBBLE);
    idle(NORM, 0, 0, RUN);

    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
    if (sbq.size() > 0) begin
      nChecks++;
      nFail++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
